// File: rtl/window_feeder.sv
// -----------------------------------------------------------------------------
// window_feeder
//
// Buffers one IMG_W x IMG_W 8-bit image from a valid/ready pixel stream, then
// presents every KxK sliding window (stride 1) to a CNN core, one per cycle.
// After the last window it waits for the core's DONE (or a TMO-cycle timeout)
// and reports the captured class for one cycle before accepting a new image.
//
// Ports
//   CLK, nRST           clock (rising edge), synchronous active-low reset
//   PIX_DATA/VALID/READY  raster-order pixel input; transfer on VALID & READY
//   START               one-cycle kick to the CNN core before streaming
//   WIN_VALID, X, Y     window valid flag and its column/row offset
//   IMGIN               KxK window, pixel (Y,X) in the top byte, row-major
//   DONE, CNN_OUT       core completion flag and class result
//   RES_VALID           one-cycle pulse qualifying RESULT and ERR
//   RESULT, ERR         captured class / timeout flag, held until next report
// -----------------------------------------------------------------------------
module window_feeder #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int TMO   = 4096
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [7:0]       PIX_DATA,
    input  logic             PIX_VALID,
    output logic             PIX_READY,
    output logic             START,
    output logic             WIN_VALID,
    output logic [4:0]       X,
    output logic [4:0]       Y,
    output logic [K*K*8-1:0] IMGIN,
    input  logic             DONE,
    input  logic [3:0]       CNN_OUT,
    output logic             RES_VALID,
    output logic [3:0]       RESULT,
    output logic             ERR
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int PW    = $clog2(NPIX);
    localparam int TW    = $clog2(TMO);
    localparam int WB    = K * K * 8;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        STREAM,
        WAIT,
        REPORT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   p_q;
    logic [4:0]      x_q, y_q;
    logic [TW-1:0]   t_q;
    logic [7:0]      pix_mem [NPIX];
    logic [WB-1:0]   win;

    logic            load_fire;
    logic            p_last, x_last, y_last, t_last;

    assign p_last = (p_q == PW'(NPIX - 1));
    assign x_last = (x_q == 5'(OUT_W - 1));
    assign y_last = (y_q == 5'(OUT_W - 1));
    assign t_last = (t_q == TW'(TMO - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        load_fire = 1'b0;
        PIX_READY = 1'b0;
        START     = 1'b0;
        WIN_VALID = 1'b0;
        RES_VALID = 1'b0;
        unique case (state_q)
            LOAD: begin
                PIX_READY = 1'b1;
                if (PIX_VALID) begin
                    load_fire = 1'b1;
                    if (p_last) state_d = KICK;
                end
            end
            KICK: begin
                START   = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                WIN_VALID = 1'b1;
                if (x_last && y_last) state_d = WAIT;
            end
            WAIT: begin
                if (DONE || t_last) state_d = REPORT;
            end
            REPORT: begin
                RES_VALID = 1'b1;
                state_d   = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            p_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            t_q    <= '0;
            RESULT <= '0;
            ERR    <= 1'b0;
        end else begin
            if (load_fire) begin
                p_q <= p_last ? '0 : p_q + 1'b1;
            end

            // X fastest; both wrap to 0 after the last window so the
            // counters already sit at the origin for the next image.
            if (state_q == STREAM) begin
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_last ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end

            // Timeout counter runs only in WAIT and is parked at 0 elsewhere.
            // DONE wins over a simultaneous timeout.
            if (state_q == WAIT) begin
                t_q <= t_q + 1'b1;
                if (DONE) begin
                    RESULT <= CNN_OUT;
                    ERR    <= 1'b0;
                end else if (t_last) begin
                    RESULT <= '0;
                    ERR    <= 1'b1;
                end
            end else begin
                t_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel store: contents are not reset; a fresh LOAD overwrites all of it.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (load_fire) begin
            pix_mem[p_q] <= PIX_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Window gather: window row i, column j comes from image pixel
    // (Y+i, X+j); element (0,0) lands in the most significant byte.
    // ------------------------------------------------------------------
    always_comb begin
        win = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win[(K*K-1-(i*K+j))*8 +: 8] =
                    pix_mem[PW'((int'(y_q) + i) * IMG_W + int'(x_q) + j)];
            end
        end
    end

    assign X     = WIN_VALID ? x_q : '0;
    assign Y     = WIN_VALID ? y_q : '0;
    assign IMGIN = WIN_VALID ? win : '0;

endmodule

// File: tb/tb_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_window_feeder
//
// Random-stimulus scoreboard bench for window_feeder. The stimulus process
// loads images, pushes every expected window and result into queues, and
// drives DONE; an independent negedge monitor pops and compares whenever the
// DUT raises WIN_VALID or RES_VALID. Expected windows come from the image
// array with direct index arithmetic.
// -----------------------------------------------------------------------------
module tb_window_feeder;

    localparam int IMG_W = 28;
    localparam int K     = 5;
    localparam int TMO   = 4096;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int NWIN  = OUT_W * OUT_W;
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int WB    = K * K * 8;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic [7:0]    PIX_DATA = '0;
    logic          PIX_VALID = 1'b0;
    logic          PIX_READY;
    logic          START;
    logic          WIN_VALID;
    logic [4:0]    X, Y;
    logic [WB-1:0] IMGIN;
    logic          DONE = 1'b0;
    logic [3:0]    CNN_OUT = '0;
    logic          RES_VALID;
    logic [3:0]    RESULT;
    logic          ERR;

    window_feeder #(.IMG_W(IMG_W), .K(K), .TMO(TMO)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .PIX_DATA  (PIX_DATA),
        .PIX_VALID (PIX_VALID),
        .PIX_READY (PIX_READY),
        .START     (START),
        .WIN_VALID (WIN_VALID),
        .X         (X),
        .Y         (Y),
        .IMGIN     (IMGIN),
        .DONE      (DONE),
        .CNN_OUT   (CNN_OUT),
        .RES_VALID (RES_VALID),
        .RESULT    (RESULT),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            x;
        int            y;
        logic [WB-1:0] w;
    } win_t;

    typedef struct {
        logic [3:0] r;
        logic       e;
        int         c;
    } res_t;

    win_t win_q[$];
    res_t res_q[$];

    logic [7:0]    img [NPIX];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    int            win_cnt, start_cnt, start_cyc, first_win_cyc, last_win_cyc;
    int            res_cnt = 0;
    int            idle_bad;
    logic [WB-1:0] w_first, w_last;

    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [WB-1:0] exp_win(input int x, input int y);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[WB-1-(i*K+j)*8 -: 8] = img[(y + i) * IMG_W + x + j];
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge CLK) begin
        if (mon_en) begin
            if (WIN_VALID === 1'b1) begin
                if (win_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL win_extra: got window x=%0d y=%0d expected none (cycle %0d)", X, Y, cyc);
                end else begin
                    win_t e;
                    e = win_q.pop_front();
                    chk("win_x", X, e.x);
                    chk("win_y", Y, e.y);
                    chk("win_data", IMGIN, e.w);
                end
                if (win_cnt == 0) first_win_cyc = cyc;
                last_win_cyc = cyc;
                if (X == 5'd0 && Y == 5'd0) w_first = IMGIN;
                if (X == 5'(OUT_W-1) && Y == 5'(OUT_W-1)) w_last = IMGIN;
                win_cnt++;
            end else if (X !== '0 || Y !== '0 || IMGIN !== '0) begin
                idle_bad++;
            end
            if (START === 1'b1) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (RES_VALID === 1'b1) begin
                res_cnt++;
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_extra: got RES_VALID result=%0d err=%0d expected none (cycle %0d)", RESULT, ERR, cyc);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("res_value", RESULT, r.r);
                    chk("res_err", ERR, r.e);
                    chk("res_cycle", cyc, r.c);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic goto_cycle(input int c);
        int g;
        g = 0;
        while (cyc < c && g < 20000) begin
            @(posedge CLK); #1;
            g++;
        end
    endtask

    task automatic load_image(input bit rnd, output int last);
        int p, g;
        bit v;
        p = 0;
        g = 0;
        last = -1;
        while (p < NPIX && g < 10000) begin
            @(posedge CLK); #1;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            PIX_VALID = v;
            PIX_DATA  = v ? img[p] : 8'($urandom);
            @(negedge CLK);
            if (v && PIX_READY === 1'b1) begin
                last = cyc;
                p++;
            end
            g++;
        end
        chk("load_count", p, NPIX);
    endtask

    // Wait for n windows, toggling DONE randomly (it must be ignored here).
    task automatic wait_wins(input int n);
        int g;
        g = 0;
        while (win_cnt < n && g < NWIN + 100) begin
            @(negedge CLK); #1;
            if (win_cnt < n) begin
                DONE    = 1'($urandom);
                CNN_OUT = 4'($urandom);
            end
            g++;
        end
        chk("win_reach", win_cnt, n);
    endtask

    // d >= 0: DONE d cycles into WAIT; d == -1: never; d == -2: reset at window 300
    task automatic run_frame(input bit pattern, input bit rnd, input int d, input logic [3:0] val);
        int last_acc, went, rc, g;
        logic [3:0] exp_r;
        logic exp_e;
        for (int p = 0; p < NPIX; p++) img[p] = pattern ? 8'(p) : 8'($urandom);
        for (int y = 0; y < OUT_W; y++)
            for (int x = 0; x < OUT_W; x++)
                win_q.push_back('{x, y, exp_win(x, y)});
        win_cnt = 0; start_cnt = 0; idle_bad = 0;
        start_cyc = -1; first_win_cyc = -1; last_win_cyc = -1;

        load_image(rnd, last_acc);
        @(posedge CLK); #1;
        PIX_VALID = 1'b1;            // junk offered outside LOAD must be ignored
        PIX_DATA  = 8'($urandom);

        if (d == -2) begin
            wait_wins(300);
            nRST = 1'b0; PIX_VALID = 1'b0; DONE = 1'b0;
            @(posedge CLK); #1;
            nRST = 1'b1;
            win_q.delete();
            @(negedge CLK); #1;
            chk("rst_win_valid", WIN_VALID, 1'b0);
            chk("rst_pix_ready", PIX_READY, 1'b1);
            chk("rst_res_valid", RES_VALID, 1'b0);
            chk("rst_start", START, 1'b0);
            chk("rst_result", RESULT, 4'd0);
            chk("rst_err", ERR, 1'b0);
            chk("rst_xy_img", {X, Y, IMGIN}, '0);
            chk("rst_win_count", win_cnt, 300);
            DONE = 1'b1; CNN_OUT = 4'd9;
            @(posedge CLK); #1;
            DONE = 1'b0;
            repeat (6) @(negedge CLK);
            #1;
            chk("rst_no_result", res_cnt, 0 + res_cnt_before_reset);
            return;
        end

        wait_wins(NWIN);
        chk("start_count", start_cnt, 1);
        chk("start_cycle", start_cyc, last_acc + 1);
        chk("first_win_cycle", first_win_cyc, last_acc + 2);
        chk("last_win_cycle", last_win_cyc, last_acc + 577);

        went = last_acc + 578;
        goto_cycle(went);
        DONE = 1'b0;
        PIX_VALID = 1'b0;
        if (d >= 0) begin
            goto_cycle(went + d);
            DONE = 1'b1; CNN_OUT = val;
            res_q.push_back('{val, 1'b0, went + d + 1});
            exp_r = val; exp_e = 1'b0;
            goto_cycle(went + d + 1);
            DONE = 1'b0; CNN_OUT = 4'($urandom);
        end else begin
            res_q.push_back('{4'd0, 1'b1, went + TMO});
            exp_r = 4'd0; exp_e = 1'b1;
        end

        rc = res_cnt;
        g = 0;
        while (res_cnt == rc && g < TMO + 100) begin
            @(negedge CLK); #1;
            g++;
        end
        chk("res_seen", res_cnt, rc + 1);
        @(negedge CLK); #1;
        chk("ready_after_report", PIX_READY, 1'b1);
        chk("idle_outputs_zero", idle_bad, 0);
        // DONE while in LOAD must not produce a report or disturb the result
        DONE = 1'b1; CNN_OUT = ~val;
        @(posedge CLK); #1;
        DONE = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("result_hold", RESULT, exp_r);
        chk("err_hold", ERR, exp_e);
        chk("win_total", win_cnt, NWIN);
        chk("res_queue_empty", res_q.size(), 0);
        if (pattern) begin
            chk("w00_byte0", w_first[199:192], 8'h00);
            chk("w00_byte1", w_first[191:184], 8'h01);
            chk("w00_row1", w_first[159:152], 8'h1C);
            chk("wlast_byte0", w_last[199:192], 8'h9B);
            chk("wlast_byte24", w_last[7:0], 8'h0F);
        end
    endtask

    int res_cnt_before_reset = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_pix_ready", PIX_READY, 1'b1);
        chk("reset_start", START, 1'b0);
        chk("reset_win_valid", WIN_VALID, 1'b0);
        chk("reset_res_valid", RES_VALID, 1'b0);
        chk("reset_result", RESULT, 4'd0);
        chk("reset_err", ERR, 1'b0);
        chk("reset_xy_img", {X, Y, IMGIN}, '0);
        #1;
        nRST = 1'b1;
        mon_en = 1'b1;

        run_frame(1'b1, 1'b0, 10, 4'd7);   // counting image, DONE after 10
        run_frame(1'b1, 1'b1, 0, 4'd12);   // same image, gappy valid, 10..15 passthrough
        run_frame(1'b0, 1'b0, -1, 4'd0);   // timeout
        res_cnt_before_reset = res_cnt;
        run_frame(1'b0, 1'b1, -2, 4'd0);   // reset mid-stream
        run_frame(1'b0, 1'b1, 37, 4'd3);   // full reload after abort

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
